encoder_32to5_stream: RTL and testbench
=======================================

ENCODER_32TO5_STREAM -- requirements
Module: encoder_32to5_stream

Interface
REQ-001 The module SHALL have one clock and its reset SHALL be synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  producer offers in_mask this cycle.
REQ-005 in_ready  output  1  block can accept a mask; high only in IDLE.
REQ-006 in_mask  input  32  multi-hot register-select vector; bit i requests register index i.
REQ-007 out_valid  output  1  out_index/out_last are valid.
REQ-008 out_ready  input  1  consumer accepts the current index.
REQ-009 out_index  output  5  binary index of the granted register.
REQ-010 out_last  output  1  high with the final index of the current mask.
REQ-011 busy  output  1  high whenever state is EMIT.

Function
REQ-012 The block SHALL implement two states: IDLE (in_ready=1, out_valid=0) and EMIT (in_ready=0, out_valid=1).
REQ-013 IDLE: in_valid=1 with a non-zero in_mask SHALL load in_mask into a 32-bit pending register and move to EMIT next cycle; latency accept-to-out_valid is exactly 1 cycle.
REQ-014 IDLE: in_valid=1 with in_mask=0 SHALL be accepted and dropped; state stays IDLE, no output produced.
REQ-015 EMIT: out_index SHALL be the binary encoding of the selected set bit of pending (selection rule per REQ-022/023).
REQ-016 EMIT: out_last SHALL be 1 iff pending holds exactly one set bit.
REQ-017 Transfer occurs when out_valid=1 and out_ready=1; the selected bit SHALL be cleared in pending at that edge.
REQ-018 Transfer with out_last=1 SHALL return to IDLE; in_ready rises the following cycle (no same-cycle reload).
REQ-019 With out_ready=0, out_index, out_last and pending SHALL hold stable.
REQ-020 Throughput SHALL be one index per cycle while out_ready=1; a mask with N set bits produces exactly N transfers, each index exactly once.
REQ-021 in_valid during EMIT SHALL be ignored (not captured); producer must hold it.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, pending=0, rotation pointer=0; out_valid=0, out_last=0, out_index=0, busy=0, in_ready=1 in the following cycle.
REQ-025 Reset mid-EMIT SHALL discard remaining pending bits with no further transfers; reset has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-022 Without ROUND_ROBIN_EN defined: selection SHALL be fixed priority, lowest set index of pending first.
REQ-023 With ROUND_ROBIN_EN defined: a 5-bit pointer SHALL select the first set bit at or above pointer, wrapping 31->0; after each transfer pointer <= out_index+1 (31 wraps to 0); pointer persists across masks and clears only on reset.

Verification
REQ-026 Reset then in_mask=32'h0000_0000 accepted -> no out_valid for 10 cycles, in_ready stays 1.
REQ-027 in_mask=32'h8000_0011, out_ready=1 -> out_index 0,4,31 on consecutive cycles, out_last only with 31, in_ready back 1 cycle after.
REQ-028 in_mask=32'h0000_0006, out_ready=0 for 5 cycles then 1 -> out_index=1 held stable 5 cycles, then 1,2 with out_last on 2.
REQ-029 in_mask=32'hFFFF_FFFF, out_ready=1 -> 32 transfers, indices 0..31 (no macro); reset asserted after index 9 -> out_valid=0 next cycle, no index 10.
REQ-030 ROUND_ROBIN_EN: mask 32'h0000_0021 (indices 0,5) then mask 32'h0000_0023 -> first mask 0,5; second mask 0,1,5 (pointer=6 wraps to 0); then mask 32'h0000_0005 gives 0,2 but after a prior transfer of index 1 gives 2,0.
REQ-031 in_valid held high during EMIT with a different mask -> ignored; captured only once IDLE and in_ready=1.

Source files
------------

// File: rtl/encoder_32to5_stream.sv
// Streams the set-bit indices of a 32-bit multi-hot mask, one index per accepted transfer.
// Optional ROUND_ROBIN_EN selects from a persistent rotating pointer instead of fixed lowest-first priority.
module encoder_32to5_stream (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_mask,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic        out_last,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [4:0]  index_q, index_d;
  logic        last_q, last_d;

  function automatic logic one_hot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

`ifdef ROUND_ROBIN_EN
  logic [4:0] ptr_q, ptr_d;

  // First set bit at or above p, wrapping 31 -> 0.
  function automatic logic [4:0] select_bit(input logic [31:0] v, input logic [4:0] p);
    logic [4:0] r;
    logic [4:0] k;
    logic       found;
    r     = '0;
    found = 1'b0;
    for (int i = 0; i < 32; i++) begin
      k = p + 5'(i);
      if (!found && v[k]) begin
        r     = k;
        found = 1'b1;
      end
    end
    return r;
  endfunction
`else
  function automatic logic [4:0] select_bit(input logic [31:0] v);
    logic [4:0] r;
    r = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) r = 5'(i);
    end
    return r;
  endfunction
`endif

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
`ifdef ROUND_ROBIN_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && (in_mask != '0)) begin
          pending_d = in_mask;
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          pending_d = pending_q & ~(32'd1 << index_q);
`ifdef ROUND_ROBIN_EN
          ptr_d     = index_q + 5'd1;
`endif
          if (last_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next pending set so they line up with the new state.
`ifdef ROUND_ROBIN_EN
    index_d = select_bit(pending_d, ptr_d);
`else
    index_d = select_bit(pending_d);
`endif
    last_d = one_hot(pending_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      index_q   <= '0;
      last_q    <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      index_q   <= index_d;
      last_q    <= last_d;
`ifdef ROUND_ROBIN_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q == EMIT);
  assign out_index = index_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_encoder_32to5_stream.sv
// Self-checking bench for encoder_32to5_stream: vector table, directed corner sequences, random masks
// checked against an ordered-index-list model (covers ROUND_ROBIN_EN when defined).
module tb_encoder_32to5_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_index;
  logic        out_last;
  logic        busy;

  encoder_32to5_stream dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int mptr  = 0;
  int exp_q[$];
  int obs_first;
  int obs_last;

  typedef struct {
    logic [31:0] mask;
    int          stall;
    int          exp_first;
    int          exp_last;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: indices emitted ascending from the pointer, then the wrapped remainder ascending.
  task automatic build_exp(input logic [31:0] m);
    int p;
`ifdef ROUND_ROBIN_EN
    p = mptr;
`else
    p = 0;
`endif
    exp_q.delete();
    for (int i = 0; i < 32; i++) if (m[i] && i >= p) exp_q.push_back(i);
    for (int i = 0; i < 32; i++) if (m[i] && i < p)  exp_q.push_back(i);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mptr  = 0;
    check("rst_in_ready",  in_ready,  1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last",  out_last,  0);
    check("rst_busy",      busy,      0);
  endtask

  task automatic send(input logic [31:0] m);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("send_timeout", 0, 1);
    in_valid = 1'b1;
    in_mask  = m;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Consumes exp_q.size() transfers with random back-pressure; stall_pct=0 demands one index per cycle.
  task automatic drain(input int stall_pct);
    int   k;
    int   t;
    bit   rdy;
    bit   prev_stall;
    int   prev_idx;
    k = 0;
    t = 0;
    prev_stall = 1'b0;
    prev_idx   = 0;
    while (k < exp_q.size() && t < 3000) begin
      rdy = ($urandom_range(99) >= stall_pct);
      check("out_valid", out_valid, 1);
      check("busy", busy, 1);
      if (prev_stall) check("hold_index", out_index, prev_idx);
      out_ready = rdy;
      if (rdy) begin
        check("index", out_index, exp_q[k]);
        check("last", out_last, (k == exp_q.size() - 1) ? 1 : 0);
        if (k == 0) obs_first = out_index;
        obs_last = out_index;
        mptr = (exp_q[k] + 1) % 32;
        k++;
      end
      prev_stall = !rdy;
      prev_idx   = out_index;
      @(negedge clk);
      t++;
    end
    out_ready = 1'b0;
    if (t >= 3000) check("drain_timeout", 0, 1);
    check("in_ready_after", in_ready, 1);
    check("out_valid_after", out_valid, 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] m;
    in_mask = '0;
    vecs[0] = '{32'h0000_0001, 0,  0,  0};
    vecs[1] = '{32'h8000_0000, 20, 31, 31};
    vecs[2] = '{32'h8000_0011, 0,  0,  31};
    vecs[3] = '{32'hFFFF_FFFF, 0,  0,  31};
    vecs[4] = '{32'h0001_0100, 50, 8,  16};
    vecs[5] = '{32'hAAAA_AAAA, 30, 1,  31};
    vecs[6] = '{32'h5555_5555, 30, 0,  30};
    vecs[7] = '{32'h0000_8000, 60, 15, 15};

    do_reset();

    // Zero mask is accepted and dropped.
    send(32'h0);
    for (int i = 0; i < 10; i++) begin
      check("zero_out_valid", out_valid, 0);
      check("zero_in_ready", in_ready, 1);
      @(negedge clk);
    end

    foreach (vecs[v]) begin
      do_reset();
      send(vecs[v].mask);
      build_exp(vecs[v].mask);
      drain(vecs[v].stall);
      check("tbl_first", obs_first, vecs[v].exp_first);
      check("tbl_last",  obs_last,  vecs[v].exp_last);
    end

    // Stalled output holds, then releases 1,2.
    do_reset();
    send(32'h0000_0006);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", out_valid, 1);
      check("stall_index", out_index, 1);
      check("stall_last",  out_last,  0);
      @(negedge clk);
    end
    exp_q = '{1, 2};
    drain(0);

    // Reset after index 9 of a full mask: no index 10, reset beats in_valid/out_ready.
    do_reset();
    send(32'hFFFF_FFFF);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      check("full_index", out_index, k);
      @(negedge clk);
    end
    reset    = 1'b1;
    in_valid = 1'b1;
    in_mask  = 32'h0000_0F00;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mptr     = 0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready",  in_ready,  1);
    check("midrst_index",     out_index, 0);
    @(negedge clk);
    check("midrst_still_idle", out_valid, 0);

    // in_valid held through EMIT with a different mask is ignored until IDLE.
    in_valid = 1'b1;
    in_mask  = 32'h0000_00F0;
    @(negedge clk);
    in_mask = 32'h0000_0003;
    build_exp(32'h0000_00F0);
    drain(40);
    @(negedge clk);
    in_valid = 1'b0;
    check("held_capture_valid", out_valid, 1);
    build_exp(32'h0000_0003);
    drain(0);

`ifdef ROUND_ROBIN_EN
    do_reset();
    send(32'h0000_0021);
    exp_q = '{0, 5};
    drain(0);
    send(32'h0000_0023);
    exp_q = '{0, 1, 5};
    drain(0);
    send(32'h0000_0005);
    exp_q = '{0, 2};
    drain(0);
    send(32'h0000_0002);
    exp_q = '{1};
    drain(0);
    send(32'h0000_0005);
    exp_q = '{2, 0};
    drain(0);
`endif

    do_reset();
    for (int r = 0; r < 60; r++) begin
      m = $urandom;
      case ($urandom_range(3))
        0: m = m & $urandom & $urandom;
        1: m = (r % 7 == 0) ? 32'h0 : (32'h1 << $urandom_range(31));
        default: ;
      endcase
      send(m);
      build_exp(m);
      drain($urandom_range(60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
